// File: rtl/dec_8b10b.sv
// 8b/10b symbol decoder with running-disparity checking and a comma-based
// link synchronisation state machine. One symbol per valid cycle, 1-cycle latency.
module dec_8b10b #(
  parameter int unsigned COMMA_COUNT = 3,
  parameter int unsigned ERR_LIMIT   = 4,
  parameter int unsigned GOOD_RUN    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [9:0] in_sym,
  output logic       out_valid,
  output logic [7:0] data,
  output logic       control,
  output logic       code_err,
  output logic       disp_err,
  output logic       comma,
  output logic       rd,
  output logic       sync
);

  localparam int unsigned CCW = $clog2(COMMA_COUNT + 1);
  localparam int unsigned EW  = $clog2(ERR_LIMIT + 1);
  localparam int unsigned GW  = $clog2(GOOD_RUN + 1);
  localparam logic [CCW-1:0] CC_LAST = CCW'(COMMA_COUNT - 1);
  localparam logic [EW-1:0]  EL_LAST = EW'(ERR_LIMIT - 1);
  localparam logic [GW-1:0]  GR_LAST = GW'(GOOD_RUN - 1);
  localparam logic [GW-1:0]  GR_MAX  = GW'(GOOD_RUN);

  typedef enum logic [1:0] {
    ST_LOS,
    ST_COMMA_DET,
    ST_SYNC
  } state_t;

  state_t           state;
  logic [CCW-1:0]   comma_cnt;
  logic [EW-1:0]    err_cnt;
  logic [GW-1:0]    good_cnt;

  logic [5:0] six;
  logic [3:0] four;
  logic [3:0] four_src;
  logic [4:0] edcba;
  logic [2:0] hgf;
  logic [2:0] ones6;
  logic [2:0] ones4;
  logic       six_ok;
  logic       four_ok;
  logic       k28;
  logic       k_alt;
  logic       code_bad;
  logic       pos6, neg6, pos4, neg4;
  logic       derr6, derr4;
  logic       rd6, rd4;
  logic       comma_n;
  logic       sym_err;

  always_comb begin
    six      = in_sym[9:4];
    four     = in_sym[3:0];
    ones6    = 3'($countones(six));
    ones4    = 3'($countones(four));
    k28      = (six == 6'b001111) || (six == 6'b110000);
    six_ok   = 1'b1;
    edcba    = '0;
    case (six)
      6'b100111, 6'b011000: edcba = 5'd0;
      6'b011101, 6'b100010: edcba = 5'd1;
      6'b101101, 6'b010010: edcba = 5'd2;
      6'b110001:            edcba = 5'd3;
      6'b110101, 6'b001010: edcba = 5'd4;
      6'b101001:            edcba = 5'd5;
      6'b011001:            edcba = 5'd6;
      6'b111000, 6'b000111: edcba = 5'd7;
      6'b111001, 6'b000110: edcba = 5'd8;
      6'b100101:            edcba = 5'd9;
      6'b010101:            edcba = 5'd10;
      6'b110100:            edcba = 5'd11;
      6'b001101:            edcba = 5'd12;
      6'b101100:            edcba = 5'd13;
      6'b011100:            edcba = 5'd14;
      6'b010111, 6'b101000: edcba = 5'd15;
      6'b011011, 6'b100100: edcba = 5'd16;
      6'b100011:            edcba = 5'd17;
      6'b010011:            edcba = 5'd18;
      6'b110010:            edcba = 5'd19;
      6'b001011:            edcba = 5'd20;
      6'b101010:            edcba = 5'd21;
      6'b011010:            edcba = 5'd22;
      6'b111010, 6'b000101: edcba = 5'd23;
      6'b110011, 6'b001100: edcba = 5'd24;
      6'b100110:            edcba = 5'd25;
      6'b010110:            edcba = 5'd26;
      6'b110110, 6'b001001: edcba = 5'd27;
      6'b001110, 6'b001111, 6'b110000: edcba = 5'd28;
      6'b101110, 6'b010001: edcba = 5'd29;
      6'b011110, 6'b100001: edcba = 5'd30;
      6'b101011, 6'b010100: edcba = 5'd31;
      default:              six_ok = 1'b0;
    endcase

    // K28 at RD+ carries the complemented 4b code, so fold it back onto the data table
    four_src = (six == 6'b110000) ? ~four : four;
    four_ok  = 1'b1;
    hgf      = '0;
    case (four_src)
      4'b1011, 4'b0100: hgf = 3'd0;
      4'b1001:          hgf = 3'd1;
      4'b0101:          hgf = 3'd2;
      4'b1100, 4'b0011: hgf = 3'd3;
      4'b1101, 4'b0010: hgf = 3'd4;
      4'b1010:          hgf = 3'd5;
      4'b0110:          hgf = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
      default:          four_ok = 1'b0;
    endcase

    k_alt = ((six == 6'b111010) || (six == 6'b000101) || (six == 6'b110110) ||
             (six == 6'b001001) || (six == 6'b101110) || (six == 6'b010001) ||
             (six == 6'b011110) || (six == 6'b100001)) &&
            ((four == 4'b0111) || (four == 4'b1000));
    code_bad = !six_ok || !four_ok;

    // Directional neutral codes behave like the sign they leave the line in
    pos6  = (ones6 > 3'd3) || (six == 6'b111000);
    neg6  = (ones6 < 3'd3) || (six == 6'b000111);
    derr6 = (pos6 && rd) || (neg6 && !rd);
    rd6   = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd);
    pos4  = (ones4 > 3'd2) || (four == 4'b1100);
    neg4  = (ones4 < 3'd2) || (four == 4'b0011);
    derr4 = (pos4 && rd6) || (neg4 && !rd6);
    rd4   = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd6);

    comma_n = (in_sym[9:3] == 7'b0011111) || (in_sym[9:3] == 7'b1100000);
    sym_err = code_bad || derr6 || derr4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data      <= '0;
      control   <= 1'b0;
      code_err  <= 1'b0;
      disp_err  <= 1'b0;
      comma     <= 1'b0;
      rd        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data     <= code_bad ? 8'h00 : {hgf, edcba};
        control  <= !code_bad && (k28 || k_alt);
        code_err <= code_bad;
        disp_err <= derr6 || derr4;
        comma    <= comma_n;
        rd       <= rd4;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_LOS;
      comma_cnt <= '0;
      err_cnt   <= '0;
      good_cnt  <= '0;
      sync      <= 1'b0;
    end else if (in_valid) begin
      case (state)
        ST_LOS: begin
          if (comma_n && !code_bad) begin
            if (COMMA_COUNT <= 1) begin
              state <= ST_SYNC;
              sync  <= 1'b1;
            end else begin
              state     <= ST_COMMA_DET;
              comma_cnt <= CCW'(1);
            end
          end
        end
        ST_COMMA_DET: begin
          if (sym_err) begin
            state     <= ST_LOS;
            comma_cnt <= '0;
          end else if (comma_n) begin
            if (comma_cnt >= CC_LAST) begin
              state     <= ST_SYNC;
              sync      <= 1'b1;
              comma_cnt <= '0;
            end else begin
              comma_cnt <= comma_cnt + 1'b1;
            end
          end
        end
        ST_SYNC: begin
          if (sym_err) begin
            good_cnt <= '0;
            if (err_cnt >= EL_LAST) begin
              state   <= ST_LOS;
              sync    <= 1'b0;
              err_cnt <= '0;
            end else begin
              err_cnt <= err_cnt + 1'b1;
            end
          end else if ((good_cnt >= GR_LAST) && (err_cnt != '0)) begin
            err_cnt  <= err_cnt - 1'b1;
            good_cnt <= '0;
          end else if (good_cnt != GR_MAX) begin
            good_cnt <= good_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_LOS;
          sync  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_8b10b.sv
// Directed-vector bench for dec_8b10b: decode values, disparity, sync FSM and reset.
module tb_dec_8b10b;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] in_sym = '0;
  logic       out_valid;
  logic [7:0] data;
  logic       control, code_err, disp_err, comma, rd, sync;
  logic [14:0] obs;

  int vectors = 0;
  int miscompares = 0;

  dec_8b10b #(.COMMA_COUNT(3), .ERR_LIMIT(4), .GOOD_RUN(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym(in_sym),
    .out_valid(out_valid), .data(data), .control(control), .code_err(code_err),
    .disp_err(disp_err), .comma(comma), .rd(rd), .sync(sync)
  );

  always #5 clk = ~clk;

  // {out_valid, data, control, code_err, disp_err, comma, rd, sync}
  assign obs = {out_valid, data, control, code_err, disp_err, comma, rd, sync};

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [9:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    in_sym = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (obs !== 15'b0) begin
      $display("FAIL reset_state got %b exp %b", obs, 15'b0); miscompares++;
    end
    send(10'h274);
    vectors++;
    if (obs !== {1'b1, 8'h00, 6'b000000}) begin
      $display("FAIL d0_0 got %b exp %b", obs, {1'b1, 8'h00, 6'b000000}); miscompares++;
    end
  endtask

  task automatic test_k28_rd();
    do_reset();
    send(10'h0FA);
    vectors++;
    if (obs !== {1'b1, 8'hBC, 6'b100110}) begin
      $display("FAIL k28_5_rdm got %b exp %b", obs, {1'b1, 8'hBC, 6'b100110}); miscompares++;
    end
    send(10'h305);
    vectors++;
    if (obs !== {1'b1, 8'hBC, 6'b100100}) begin
      $display("FAIL k28_5_rdp got %b exp %b", obs, {1'b1, 8'hBC, 6'b100100}); miscompares++;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== {1'b0, 8'hBC, 6'b100100}) begin
      $display("FAIL idle_hold got %b exp %b", obs, {1'b0, 8'hBC, 6'b100100}); miscompares++;
    end
  endtask

  task automatic test_disp_err();
    do_reset();
    send(10'h305);
    vectors++;
    if (obs !== {1'b1, 8'hBC, 6'b101100}) begin
      $display("FAIL disp_err_k28 got %b exp %b", obs, {1'b1, 8'hBC, 6'b101100}); miscompares++;
    end
  endtask

  task automatic test_code_err();
    do_reset();
    send(10'h000);
    vectors++;
    if (obs !== {1'b1, 8'h00, 6'b011000}) begin
      $display("FAIL code_err_000 got %b exp %b", obs, {1'b1, 8'h00, 6'b011000}); miscompares++;
    end
    // FSM must still be in loss-of-sync: three more commas needed
    send(10'h0FA);
    send(10'h305);
    vectors++;
    if (sync !== 1'b0) begin
      $display("FAIL code_err_los_2nd got %b exp %b", sync, 1'b0); miscompares++;
    end
    send(10'h0FA);
    vectors++;
    if (sync !== 1'b1) begin
      $display("FAIL code_err_los_3rd got %b exp %b", sync, 1'b1); miscompares++;
    end
    do_reset();
    send(10'h3CB);
    vectors++;
    if (obs !== {1'b1, 8'h00, 6'b011010}) begin
      $display("FAIL bad_6b got %b exp %b", obs, {1'b1, 8'h00, 6'b011010}); miscompares++;
    end
  endtask

  task automatic test_special_codes();
    do_reset();
    send(10'h3A8);
    vectors++;
    if (obs !== {1'b1, 8'hF7, 6'b100000}) begin
      $display("FAIL k23_7 got %b exp %b", obs, {1'b1, 8'hF7, 6'b100000}); miscompares++;
    end
    do_reset();
    send(10'h237);
    vectors++;
    if (obs !== {1'b1, 8'hF1, 6'b000010}) begin
      $display("FAIL d17_a7 got %b exp %b", obs, {1'b1, 8'hF1, 6'b000010}); miscompares++;
    end
  endtask

  task automatic test_sync();
    logic [9:0]  seq [5];
    logic [14:0] exp_seq [5];
    seq = '{10'h0FA, 10'h2AA, 10'h305, 10'h2AA, 10'h0FA};
    exp_seq = '{{1'b1, 8'hBC, 6'b100110}, {1'b1, 8'hB5, 6'b000010},
                {1'b1, 8'hBC, 6'b100100}, {1'b1, 8'hB5, 6'b000000},
                {1'b1, 8'hBC, 6'b100111}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(seq[i]);
      vectors++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL sync_seq[%0d] got %b exp %b", i, obs, exp_seq[i]); miscompares++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(10'h000);
      vectors++;
      if (obs !== {1'b1, 8'h00, 5'b01100, (i < 3)}) begin
        $display("FAIL sync_loss[%0d] got %b exp %b", i, obs, {1'b1, 8'h00, 5'b01100, (i < 3)});
        miscompares++;
      end
    end
  endtask

  task automatic test_err_recovery();
    do_reset();
    send(10'h0FA);
    send(10'h305);
    send(10'h0FA);
    for (int i = 0; i < 3; i++) begin
      send(10'h000);
      vectors++;
      if (sync !== 1'b1) begin
        $display("FAIL recov_err[%0d] got %b exp %b", i, sync, 1'b1); miscompares++;
      end
    end
    repeat (4) send(10'h2AA);
    send(10'h000);
    vectors++;
    if (sync !== 1'b1) begin
      $display("FAIL recov_after_good got %b exp %b", sync, 1'b1); miscompares++;
    end
    send(10'h000);
    vectors++;
    if (sync !== 1'b0) begin
      $display("FAIL recov_limit got %b exp %b", sync, 1'b0); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(10'h0FA);
    send(10'h305);
    send(10'h0FA);
    @(negedge clk);
    in_valid = 1'b1;
    in_sym = 10'h2AA;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 15'b0) begin
      $display("FAIL mid_reset got %b exp %b", obs, 15'b0); miscompares++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send(10'h274);
    vectors++;
    if (obs !== {1'b1, 8'h00, 6'b000000}) begin
      $display("FAIL post_reset got %b exp %b", obs, {1'b1, 8'h00, 6'b000000}); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_k28_rd();
    test_disp_err();
    test_code_err();
    test_special_codes();
    test_sync();
    test_err_recovery();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
